hack_screen_scanout: RTL
========================

Name: hack_screen_scanout

Overview:
- Scanout controller for the nand2tetris Hack screen: 512x256 monochrome, 8K x 16-bit screen RAM, shown centred in the 640x480 HDMI raster.
- Tracks raster position from the hdmi timing strobes (enable/newline/newframe).
- Prefetches screen-RAM words ahead of the beam and produces the 24-bit pixel fed to the hdmi block.
- Runs entirely in the 25 MHz pixel clock domain.

Parameters:
- H_OFFSET, 64: first active-pixel column of the Hack screen inside the 640-wide line.
- V_OFFSET, 112: first active line of the Hack screen inside the 480-line frame.
- FG_COLOR, 24'h000000: colour for a screen bit = 1.
- BG_COLOR, 24'hFFFFFF: colour for a screen bit = 0.
- BORDER_COLOR, 24'h404040: colour outside the 512x256 window, and while unsynced.

Ports:
- clk  input  1  pixel clock (25 MHz).
- rst  input  1  asynchronous, active-low reset.
- i_enable  input  1  hdmi active-video strobe, one cycle per visible pixel.
- i_newline  input  1  one-cycle pulse in horizontal blanking before each active line.
- i_newframe  input  1  one-cycle pulse in vertical blanking before line 0.
- o_mem_addr  output  13  screen RAM read address, {row[7:0], col[4:0]}.
- o_mem_rd  output  1  read strobe, one cycle.
- i_mem_data  input  16  read data, valid exactly 1 cycle after o_mem_rd.
- o_pixel  output  24  RGB pixel, registered.
- o_de  output  1  i_enable delayed 1 cycle (qualifies o_pixel).
- o_frame_irq  output  1  one-cycle pulse, registered copy of i_newframe.
- o_synced  output  1  high once the first i_newframe has been seen after reset.

Behaviour:
Reset:
- Asynchronous on rst low. All outputs return to 0 except o_pixel, which returns to BORDER_COLOR.
- All counters and word registers clear to 0; state returns to UNSYNCED.

States (UNSYNCED, SYNCED):
- UNSYNCED -> SYNCED on i_newframe. There is no exit except reset.
- In UNSYNCED: o_mem_rd stays 0 and every o_pixel is BORDER_COLOR.

Raster counters:
- x[9:0] increments on each cycle with i_enable=1.
- x clears on the i_enable falling edge; the falling edge also increments y[8:0].
- i_newframe clears y to 0 and takes precedence over a same-cycle y increment.
- x saturates at 1023 and y at 511, with no wrap.

Active window:
- Inside when H_OFFSET <= x < H_OFFSET+512 and V_OFFSET <= y < V_OFFSET+256.
- Screen coordinates: r = y - V_OFFSET (8 bits), c = (x - H_OFFSET)>>4 (5 bits), b = (x - H_OFFSET)&15.

Word buffering (two registers, cur and nxt):
- Line prefetch: on i_newline in SYNCED with y in the window, issue o_mem_rd with addr {r,5'd0}.
- Data capture: the cycle after any o_mem_rd, nxt <= i_mem_data.
- Word load: on an enable cycle with x == H_OFFSET+16k-1 (k = 0..31), cur <= nxt.
- In-line fetch: on an enable cycle with x == H_OFFSET+16k (k = 0..30) and y in the window, issue o_mem_rd with addr {r,k+1}.
- At most one read is outstanding. Exactly 32 reads per active line, none outside the window.

Pixel output (latency 1):
- o_pixel(t+1) = cur[b] ? FG_COLOR : BG_COLOR if (t) is an enable cycle inside the window.
- Otherwise o_pixel(t+1) = BORDER_COLOR.
- Bit 0 is the leftmost pixel of a word.
- o_de(t+1) = i_enable(t).
- The integrating top delays its hdmi pixel inputs to match this 1-cycle latency.

Integration requirements:
- i_newline is asserted at least 2 cycles before i_enable rises.
- i_newline is asserted after the previous line's enable has fallen.
- Violating either is an integration error; the block still outputs stale cur data and does not hang.

Simultaneous events:
- i_newframe together with i_newline: y is cleared first; the prefetch uses y=0, so it is outside the window and no read is issued.

Reset mid-frame:
- Outputs revert to reset values and the state returns to UNSYNCED.
- Border colour is output until the next i_newframe.

Decomposition:
- Package hack_video_pkg:
  - screen geometry constants: 512, 256, 32 words/row, 640x480;
  - the rgb_t 24-bit typedef;
  - the scan_state_e enum {UNSYNCED, SYNCED}.
- Sub-module hack_raster_counter: x/y counters, edge detection and the window/coordinate decode.
- Fetch, word buffering and pixel muxing stay in the top-level module.

Test Plan:
1. Reset, then timing strobes with no i_newframe for one full frame -> o_synced=0, o_mem_rd never asserted, every o_de-qualified o_pixel = 24'h404040.
2. RAM model with latency 1, word[0]=16'h0001, rest 0; full frame -> at y=112, x=64 o_pixel=000000; x=65..575 FFFFFF; o_mem_rd count = 8192 per frame, addresses 0..8191 in order.
3. RAM word[8191]=16'h8000 -> only pixel (x=575, y=367) = 000000; x=576 and y=368 = 404040.
4. Row 0 alternating 16'hAAAA -> pixels at x=64,65,66,67 = FFFFFF,000000,FFFFFF,000000; o_pixel changes exactly 1 cycle after the corresponding i_enable cycle.
5. i_newframe and i_newline in the same cycle -> y=0, no read issued; o_frame_irq pulses once, 1 cycle later.
6. rst low at y=200, x=300 -> o_pixel=404040 and o_de=0 immediately (asynchronous); after release, border only until the next i_newframe, then row 0 displays correctly.

Source files
------------

// File: rtl/hack_video_pkg.sv
// Shared geometry, pixel type and scan state for the Hack screen scanout path.
package hack_video_pkg;

  localparam int SCREEN_W      = 512;
  localparam int SCREEN_H      = 256;
  localparam int WORDS_PER_ROW = 32;
  localparam int RASTER_W      = 640;
  localparam int RASTER_H      = 480;
  localparam int ADDR_W        = 13;
  localparam int WORD_W        = 16;

  typedef logic [23:0] rgb_t;

  typedef enum logic {
    UNSYNCED = 1'b0,
    SYNCED   = 1'b1
  } scan_state_e;

  function automatic rgb_t pick_color(input logic bit_on, input rgb_t fg, input rgb_t bg);
    return bit_on ? fg : bg;
  endfunction

endpackage

// File: rtl/hack_raster_counter.sv
// Raster position tracking from the hdmi strobes plus the Hack-window and
// screen-coordinate decode used by the fetch and pixel logic.
module hack_raster_counter
  import hack_video_pkg::*;
#(
  parameter int H_OFFSET = 64,
  parameter int V_OFFSET = 112
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       newframe,
  output logic       in_win,
  output logic [7:0] row,
  output logic [4:0] col,
  output logic [3:0] bit_idx,
  output logic       load_hit,
  output logic       fetch_hit,
  output logic       line_in_win,
  output logic [7:0] line_row
);

  localparam logic [9:0]  X_LO     = 10'(H_OFFSET);
  localparam logic [9:0]  X_HI     = 10'(H_OFFSET + SCREEN_W);
  localparam logic [10:0] XN_LO    = 11'(H_OFFSET);
  localparam logic [10:0] XN_HI    = 11'(H_OFFSET + SCREEN_W);
  localparam logic [8:0]  Y_LO     = 9'(V_OFFSET);
  localparam logic [8:0]  Y_HI     = 9'(V_OFFSET + SCREEN_H);
  localparam logic [4:0]  LAST_COL = 5'(WORDS_PER_ROW - 1);

  logic [9:0]  x;
  logic [8:0]  y;
  logic        en_d;
  logic        fall;
  logic        x_in;
  logic        y_in;
  logic [8:0]  x_rel;
  logic [10:0] x_next;
  logic [3:0]  x_next_bit;
  logic [8:0]  y_line;

  assign fall = en_d & ~enable;

  // Both counters saturate rather than wrap so malformed timing cannot
  // alias back into the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x    <= '0;
      y    <= '0;
      en_d <= 1'b0;
    end else begin
      en_d <= enable;
      if (fall) begin
        x <= '0;
      end else if (enable && (x != 10'h3FF)) begin
        x <= x + 10'd1;
      end
      if (newframe) begin
        y <= '0;
      end else if (fall && (y != 9'h1FF)) begin
        y <= y + 9'd1;
      end
    end
  end

  assign x_in    = (x >= X_LO) && (x < X_HI);
  assign y_in    = (y >= Y_LO) && (y < Y_HI);
  assign in_win  = x_in & y_in;
  assign x_rel   = 9'(x - X_LO);
  assign row     = 8'(y - Y_LO);
  assign col     = x_rel[8:4];
  assign bit_idx = x_rel[3:0];

  // The cycle before each 16-pixel word boundary hands nxt over to cur.
  assign x_next     = {1'b0, x} + 11'd1;
  assign x_next_bit = 4'(x_next - XN_LO);
  assign load_hit   = (x_next >= XN_LO) && (x_next < XN_HI) && (x_next_bit == 4'd0);

  assign fetch_hit = in_win && (bit_idx == 4'd0) && (col != LAST_COL);

  // A newframe arriving with newline clears y before the line prefetch looks at it.
  assign y_line      = newframe ? 9'd0 : y;
  assign line_in_win = (y_line >= Y_LO) && (y_line < Y_HI);
  assign line_row    = 8'(y_line - Y_LO);

endmodule

// File: rtl/hack_screen_scanout.sv
// Hack 512x256 screen scanout: prefetches screen-RAM words ahead of the beam
// and emits one registered 24-bit pixel per hdmi enable cycle.
module hack_screen_scanout
  import hack_video_pkg::*;
#(
  parameter int   H_OFFSET     = (RASTER_W - SCREEN_W) / 2,
  parameter int   V_OFFSET     = (RASTER_H - SCREEN_H) / 2,
  parameter rgb_t FG_COLOR     = 24'h000000,
  parameter rgb_t BG_COLOR     = 24'hFFFFFF,
  parameter rgb_t BORDER_COLOR = 24'h404040
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_newline,
  input  logic              i_newframe,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [WORD_W-1:0] i_mem_data,
  output rgb_t              o_pixel,
  output logic              o_de,
  output logic              o_frame_irq,
  output logic              o_synced
);

  scan_state_e       state;
  logic [WORD_W-1:0] cur;
  logic [WORD_W-1:0] nxt;
  logic              rd_pend;

  logic              in_win;
  logic [7:0]        row;
  logic [4:0]        col;
  logic [3:0]        bit_idx;
  logic              load_hit;
  logic              fetch_hit;
  logic              line_in_win;
  logic [7:0]        line_row;

  hack_raster_counter #(
    .H_OFFSET (H_OFFSET),
    .V_OFFSET (V_OFFSET)
  ) u_raster (
    .clk         (clk),
    .rst         (rst),
    .enable      (i_enable),
    .newframe    (i_newframe),
    .in_win      (in_win),
    .row         (row),
    .col         (col),
    .bit_idx     (bit_idx),
    .load_hit    (load_hit),
    .fetch_hit   (fetch_hit),
    .line_in_win (line_in_win),
    .line_row    (line_row)
  );

  assign o_synced = (state == SYNCED);

  // Read port: o_mem_rd is a one-cycle request with no back-pressure; the RAM
  // answers on i_mem_data exactly one cycle later, which is captured into nxt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= UNSYNCED;
      o_mem_addr  <= '0;
      o_mem_rd    <= 1'b0;
      rd_pend     <= 1'b0;
      nxt         <= '0;
      cur         <= '0;
      o_pixel     <= BORDER_COLOR;
      o_de        <= 1'b0;
      o_frame_irq <= 1'b0;
    end else begin
      o_de        <= i_enable;
      o_frame_irq <= i_newframe;
      rd_pend     <= o_mem_rd;
      o_mem_rd    <= 1'b0;
      if (rd_pend) begin
        nxt <= i_mem_data;
      end
      if (i_enable && load_hit) begin
        cur <= nxt;
      end
      case (state)
        UNSYNCED: begin
          o_pixel <= BORDER_COLOR;
          if (i_newframe) begin
            state <= SYNCED;
          end
        end
        SYNCED: begin
          // Word 0 is fetched during blanking; words 1..31 one word ahead of the beam.
          if (i_newline && line_in_win) begin
            o_mem_rd   <= 1'b1;
            o_mem_addr <= {line_row, 5'd0};
          end else if (i_enable && fetch_hit) begin
            o_mem_rd   <= 1'b1;
            o_mem_addr <= {row, col + 5'd1};
          end
          if (i_enable && in_win) begin
            o_pixel <= pick_color(cur[bit_idx], FG_COLOR, BG_COLOR);
          end else begin
            o_pixel <= BORDER_COLOR;
          end
        end
        default: begin
          state   <= UNSYNCED;
          o_pixel <= BORDER_COLOR;
        end
      endcase
    end
  end

endmodule
